// File: rtl/cpu_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// cpu_mem_arbiter_if
//
// Purpose:
//   Generic single-transaction memory bus used on all three sides of
//   cpu_mem_arbiter: the instruction port, the data port and the physical
//   memory port. A requester drives the strobes, address, write data and byte
//   mask. The responder returns a one-cycle resp pulse together with the read
//   data.
//
// Signals:
//   read         requester -> responder  read strobe / request
//   write        requester -> responder  write strobe / request
//   address      requester -> responder  ADDR_WIDTH address
//   wdata        requester -> responder  DATA_WIDTH write data
//   byte_enable  requester -> responder  MASK_WIDTH write byte mask
//   resp         responder -> requester  completion pulse
//   rdata        responder -> requester  read data, valid with resp
//
// Modports:
//   master  the side that issues requests
//   slave   the side that answers them
// -----------------------------------------------------------------------------
interface cpu_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MASK_WIDTH = 2
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] byte_enable;
    logic                  resp;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output read,
        output write,
        output address,
        output wdata,
        output byte_enable,
        input  resp,
        input  rdata
    );

    modport slave (
        input  read,
        input  write,
        input  address,
        input  wdata,
        input  byte_enable,
        output resp,
        output rdata
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_mem_arbiter
//
// Purpose:
//   Merges the instruction port and the data port of cpu_datapath onto one
//   physical memory port. Only one transaction is in flight at a time. When
//   both ports request in the same IDLE cycle, the grant goes to the port
//   opposite the previous grant. This keeps the always-requesting instruction
//   port from starving data accesses. After reset the data port wins the
//   first tie.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   i_mem  slave   instruction port; only read/address are used
//   d_mem  slave   data port; read, write, address, wdata, byte_enable
//   pmem   master  physical memory port
//
// Behaviour summary:
//   IDLE   -> grant edge latches address/wdata/mask/op from the winner
//   *_BUSY -> pmem_* driven purely from the latches until pmem.resp
//   On pmem.resp the granted port sees resp and rdata in the same cycle.
//   The next edge returns to IDLE, so consecutive transactions are always
//   separated by one IDLE cycle.
// -----------------------------------------------------------------------------
module cpu_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MASK_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_mem_arbiter_if.slave      i_mem,
    cpu_mem_arbiter_if.slave      d_mem,
    cpu_mem_arbiter_if.master     pmem
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_e;

    state_e                state_q,    state_d;
    logic                  last_d_q,   last_d_d;  // 1: data port won the last grant
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [MASK_WIDTH-1:0] be_q,       be_d;
    logic                  wr_q,       wr_d;       // latched operation: 1 = write

    logic i_req;
    logic d_req;
    logic busy;

    // The instruction port never writes. Its write-side signals exist only
    // because it shares the bus interface type.
    logic unused_i_write_side;
    assign unused_i_write_side = ^{i_mem.write, i_mem.wdata, i_mem.byte_enable};

    assign i_req = i_mem.read;
    assign d_req = d_mem.read | d_mem.write;
    assign busy  = (state_q != IDLE);

    // -------------------------------------------------------------------------
    // State and request latches
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            wr_q     <= wr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and grant logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        wr_d     = wr_q;

        unique case (state_q)
            IDLE: begin
                // Data wins when it is alone, or when it ties and the
                // instruction port was served last.
                if (d_req && (!i_req || !last_d_q)) begin
                    state_d  = D_BUSY;
                    last_d_d = 1'b1;
                    addr_d   = d_mem.address;
                    // Read+write together is treated as a write.
                    wr_d     = d_mem.write;
                    wdata_d  = d_mem.write ? d_mem.wdata : '0;
                    be_d     = d_mem.write ? d_mem.byte_enable : '1;
                end else if (i_req) begin
                    state_d  = I_BUSY;
                    last_d_d = 1'b0;
                    addr_d   = i_mem.address;
                    wr_d     = 1'b0;
                    wdata_d  = '0;
                    be_d     = '1;
                end
            end

            I_BUSY, D_BUSY: begin
                // Requester inputs are ignored here, so a withdrawn request
                // still runs to completion.
                if (pmem.resp) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        pmem.read        = 1'b0;
        pmem.write       = 1'b0;
        pmem.address     = '0;
        pmem.wdata       = '0;
        pmem.byte_enable = '0;
        i_mem.resp       = 1'b0;
        i_mem.rdata      = '0;
        d_mem.resp       = 1'b0;
        d_mem.rdata      = '0;

        if (busy) begin
            pmem.read        = ~wr_q;
            pmem.write       = wr_q;
            pmem.address     = addr_q;
            pmem.wdata       = wdata_q;
            pmem.byte_enable = be_q;
        end

        // Completion is passed straight through in the resp cycle. A
        // pmem.resp seen while IDLE produces nothing.
        if (state_q == I_BUSY && pmem.resp) begin
            i_mem.resp  = 1'b1;
            i_mem.rdata = pmem.rdata;
        end
        if (state_q == D_BUSY && pmem.resp) begin
            d_mem.resp  = 1'b1;
            d_mem.rdata = pmem.rdata;
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
module tb_cpu_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 2;

    logic clk;
    logic rst;

    int n_chk;
    int n_bad;

    cpu_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) i_if ();
    cpu_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) d_if ();
    cpu_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) p_if ();

    cpu_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_mem (i_if.slave),
        .d_mem (d_if.slave),
        .pmem  (p_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled around the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_if.read        = 1'b0;
        i_if.write       = 1'b0;
        i_if.address     = '0;
        i_if.wdata       = '0;
        i_if.byte_enable = '0;
        d_if.read        = 1'b0;
        d_if.write       = 1'b0;
        d_if.address     = '0;
        d_if.wdata       = '0;
        d_if.byte_enable = '0;
        p_if.resp        = 1'b0;
        p_if.rdata       = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Wait (bounded) for a strobe, check which port was granted, then answer.
    task automatic serve(input string tag, input logic exp_d, input logic [15:0] exp_addr,
                         input logic [15:0] rd);
        int k;
        k = 0;
        while (!(p_if.read || p_if.write) && k < 8) begin
            step();
            k++;
        end
        chk({tag, "_strobe"}, {31'd0, p_if.read}, 32'd1);
        chk({tag, "_addr"}, {16'd0, p_if.address}, {16'd0, exp_addr});
        p_if.resp  = 1'b1;
        p_if.rdata = rd;
        #1;
        chk({tag, "_dresp"}, {31'd0, d_if.resp}, {31'd0, exp_d});
        chk({tag, "_iresp"}, {31'd0, i_if.resp}, {31'd0, ~exp_d});
        chk({tag, "_rdata"}, {16'd0, (exp_d ? d_if.rdata : i_if.rdata)}, {16'd0, rd});
        step();
        p_if.resp  = 1'b0;
        p_if.rdata = '0;
        #1;
        chk({tag, "_idle"}, {30'd0, p_if.read, p_if.write}, 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        // Reset state
        chk("rst_strobes", {30'd0, p_if.read, p_if.write}, 32'd0);
        chk("rst_addr", {16'd0, p_if.address}, 32'd0);
        chk("rst_resps", {30'd0, i_if.resp, d_if.resp}, 32'd0);
        rst = 1'b0;
        step();

        // 1. Instruction fetch only, pmem answers on the third busy cycle
        i_if.read    = 1'b1;
        i_if.address = 16'h0040;
        #1;
        chk("t1_pre", {31'd0, p_if.read}, 32'd0);
        step();
        chk("t1_read", {31'd0, p_if.read}, 32'd1);
        chk("t1_write", {31'd0, p_if.write}, 32'd0);
        chk("t1_addr", {16'd0, p_if.address}, 32'h0040);
        chk("t1_be", {30'd0, p_if.byte_enable}, 32'd3);
        step();
        step();
        chk("t1_hold", {31'd0, p_if.read}, 32'd1);
        chk("t1_noresp", {31'd0, i_if.resp}, 32'd0);
        i_if.read  = 1'b0;
        p_if.resp  = 1'b1;
        p_if.rdata = 16'h1234;
        #1;
        chk("t1_iresp", {31'd0, i_if.resp}, 32'd1);
        chk("t1_irdata", {16'd0, i_if.rdata}, 32'h1234);
        chk("t1_dresp", {31'd0, d_if.resp}, 32'd0);
        chk("t1_drdata", {16'd0, d_if.rdata}, 32'd0);
        step();
        p_if.resp  = 1'b0;
        p_if.rdata = '0;
        #1;
        chk("t1_end_read", {31'd0, p_if.read}, 32'd0);
        chk("t1_end_rdata", {16'd0, i_if.rdata}, 32'd0);
        step();

        // 2. Data write, request withdrawn while busy
        d_if.write       = 1'b1;
        d_if.address     = 16'h2001;
        d_if.wdata       = 16'hABCD;
        d_if.byte_enable = 2'b10;
        step();
        chk("t2_write", {31'd0, p_if.write}, 32'd1);
        chk("t2_read", {31'd0, p_if.read}, 32'd0);
        chk("t2_addr", {16'd0, p_if.address}, 32'h2001);
        chk("t2_wdata", {16'd0, p_if.wdata}, 32'hABCD);
        chk("t2_be", {30'd0, p_if.byte_enable}, 32'd2);
        d_if.write = 1'b0;
        step();
        chk("t2_withdraw_hold", {31'd0, p_if.write}, 32'd1);
        p_if.resp = 1'b1;
        #1;
        chk("t2_dresp", {31'd0, d_if.resp}, 32'd1);
        chk("t2_iresp", {31'd0, i_if.resp}, 32'd0);
        step();
        p_if.resp = 1'b0;
        #1;
        chk("t2_single_pulse", {31'd0, d_if.resp}, 32'd0);
        chk("t2_end_write", {31'd0, p_if.write}, 32'd0);
        step();

        // 3. Contention right after reset: D, I, D, I
        do_reset();
        i_if.read    = 1'b1;
        i_if.address = 16'h0100;
        d_if.read    = 1'b1;
        d_if.address = 16'h0200;
        step();
        serve("t3_g0", 1'b1, 16'h0200, 16'hD000);
        serve("t3_g1", 1'b0, 16'h0100, 16'h1001);
        serve("t3_g2", 1'b1, 16'h0200, 16'hD002);
        serve("t3_g3", 1'b0, 16'h0100, 16'h1003);
        idle_inputs();
        step();
        step();

        // 4. Address change while busy is ignored
        d_if.read    = 1'b1;
        d_if.address = 16'h3000;
        step();
        chk("t4_addr0", {16'd0, p_if.address}, 32'h3000);
        d_if.address = 16'h4000;
        step();
        chk("t4_addr1", {16'd0, p_if.address}, 32'h3000);
        step();
        chk("t4_addr2", {16'd0, p_if.address}, 32'h3000);
        p_if.resp  = 1'b1;
        p_if.rdata = 16'h0BEE;
        #1;
        chk("t4_addr_resp", {16'd0, p_if.address}, 32'h3000);
        chk("t4_dresp", {31'd0, d_if.resp}, 32'd1);
        chk("t4_drdata", {16'd0, d_if.rdata}, 32'h0BEE);
        d_if.read = 1'b0;
        step();
        p_if.resp  = 1'b0;
        p_if.rdata = '0;
        step();

        // 5. Reset in the middle of a data access, late pmem resp dropped
        d_if.read    = 1'b1;
        d_if.address = 16'h5000;
        step();
        chk("t5_busy", {31'd0, p_if.read}, 32'd1);
        rst       = 1'b1;
        d_if.read = 1'b0;
        #1;
        chk("t5_rst_strobes", {30'd0, p_if.read, p_if.write}, 32'd0);
        chk("t5_rst_addr", {16'd0, p_if.address}, 32'd0);
        step();
        chk("t5_rst_hold", {30'd0, p_if.read, p_if.write}, 32'd0);
        rst = 1'b0;
        step();
        p_if.resp  = 1'b1;
        p_if.rdata = 16'hDEAD;
        #1;
        chk("t5_no_dresp", {31'd0, d_if.resp}, 32'd0);
        chk("t5_no_iresp", {31'd0, i_if.resp}, 32'd0);
        chk("t5_no_rdata", {16'd0, d_if.rdata}, 32'd0);
        step();
        p_if.resp  = 1'b0;
        p_if.rdata = '0;
        step();

        // 6. Read and write together behave as a write
        d_if.read        = 1'b1;
        d_if.write       = 1'b1;
        d_if.address     = 16'h6000;
        d_if.wdata       = 16'h00FF;
        d_if.byte_enable = 2'b01;
        step();
        chk("t6_write", {31'd0, p_if.write}, 32'd1);
        chk("t6_read", {31'd0, p_if.read}, 32'd0);
        chk("t6_be", {30'd0, p_if.byte_enable}, 32'd1);
        chk("t6_wdata", {16'd0, p_if.wdata}, 32'h00FF);
        d_if.read  = 1'b0;
        d_if.write = 1'b0;
        p_if.resp  = 1'b1;
        #1;
        chk("t6_dresp", {31'd0, d_if.resp}, 32'd1);
        step();
        p_if.resp = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
